vga_dram_writer: RTL and testbench

//  Writes a 16bpp pixel stream into the SDRAM framebuffer over an Avalon-MM write master.

---
 rtl/vga_dram_writer.sv | 180 ++++++++++++++++++
 tb/tb_vga_dram_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dram_writer.sv
// ---------------------------------------------------------------------------
// vga_dram_writer
//
// Packs a 16bpp pixel stream into 32-bit words (first pixel in [15:0],
// second pixel in [31:16]) and writes them into the SDRAM framebuffer through
// an Avalon-MM write master. A small first-word-fall-through FIFO absorbs
// SDRAM stalls so the producer is back-pressured instead of losing data.
//
// Ports
//   clk                 system clock
//   resetn              asynchronous active-low reset
//   start               begin a frame (only honoured while idle)
//   write_to_addr       frame base byte address (low two bits ignored)
//   flush               end the frame early, writing out any held half-word
//   pixel_in            16-bit pixel (1:5:5:5)
//   pixel_valid         producer offers a pixel
//   pixel_ready         pixel taken when pixel_valid && pixel_ready
//   busy                high from start until done
//   done                one-cycle pulse once every word has been written
//   master_address      Avalon byte address
//   master_write        Avalon write request
//   master_writedata    Avalon write data
//   master_byteenable   Avalon byte enables
//   master_wait_request Avalon stall
// ---------------------------------------------------------------------------
module vga_dram_writer #(
  parameter int TOTAL_WORDS = 240000,
  parameter int WORDS_W     = 18,
  parameter int FIFO_AW     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] write_to_addr,
  input  logic        flush,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  input  logic        master_wait_request
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [WORDS_W-1:0] TOTAL     = WORDS_W'(TOTAL_WORDS);

  logic [1:0]         state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [WORDS_W-1:0] pushed_q, pushed_d;
  logic [WORDS_W-1:0] written_q, written_d;
  logic [15:0]        hold_q, hold_d;
  logic               holdValid_q, holdValid_d;
  logic               done_q, done_d;

  // FIFO entries are {byteenable[3:0], data[31:0]}
  logic [35:0]        fifoMem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
  logic [FIFO_AW:0]   count_q;

  logic        fifoEmpty;
  logic        accept;
  logic        pushOdd;
  logic        pushFlush;
  logic        push;
  logic        pop;
  logic [35:0] pushWord;
  logic [35:0] headWord;

  assign fifoEmpty = (count_q == '0);

  // flush gates pixel_ready combinationally so a pixel offered together with
  // flush is never taken.
  assign pixel_ready = (state_q == RUN) && !flush && (count_q < FIFO_FULL) && (pushed_q < TOTAL);
  assign accept      = pixel_valid && pixel_ready;

  // A held pixel always means the FIFO has room: the FIFO can only fill on an
  // odd-pixel push, which also empties the holding register.
  assign pushOdd   = accept && holdValid_q;
  assign pushFlush = (state_q == RUN) && flush && holdValid_q;
  assign push      = pushOdd || pushFlush;
  assign pushWord  = pushOdd ? {4'b1111, pixel_in, hold_q} : {4'b0011, 16'h0000, hold_q};

  assign headWord          = fifoMem_q[rdPtr_q];
  assign master_write      = !fifoEmpty && (state_q != IDLE);
  assign master_writedata  = fifoEmpty ? 32'h0 : headWord[31:0];
  assign master_byteenable = fifoEmpty ? 4'h0 : headWord[35:32];
  assign master_address    = base_q + (32'(written_q) << 2);
  assign pop               = master_write && !master_wait_request;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pushed_d    = pushed_q;
    written_d   = written_q;
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = write_to_addr & 32'hFFFF_FFFC;
          pushed_d    = '0;
          written_d   = '0;
          holdValid_d = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (flush || (pushed_q == TOTAL)) state_d = DRAIN;
      end
      DRAIN: begin
        // An empty FIFO means every word has been accepted by the slave.
        if (fifoEmpty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && !holdValid_q) begin
      hold_d      = pixel_in;
      holdValid_d = 1'b1;
    end
    if (push) begin
      holdValid_d = 1'b0;
      pushed_d    = pushed_q + 1'b1;
    end
    if (pop) written_d = written_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      pushed_q    <= '0;
      written_q   <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      done_q      <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pushed_q    <= pushed_d;
      written_q   <= written_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      done_q      <= done_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= pushWord;
  end

endmodule

// File: tb/tb_vga_dram_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_dram_writer
//
// Drives two instances of vga_dram_writer: one with the full-frame word count
// and one with a four-word frame so the natural end-of-frame path is reachable.
// Inputs change on the falling clock edge; outputs are observed shortly after.
// ---------------------------------------------------------------------------
module tb_vga_dram_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } writeRec_t;

  typedef struct {
    logic [31:0] baseAddr;
    logic [15:0] pix0;
    logic [15:0] pix1;
    logic        twoPix;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expBe;
  } vector_t;

  logic        clk;
  logic        resetn;
  logic [31:0] writeToAddr;
  logic        waitReq;

  logic        start, flush, pixelValid;
  logic [15:0] pixelIn;
  logic        pixelReady, busy, done, mWrite;
  logic [31:0] mAddr, mData;
  logic [3:0]  mBe;

  logic        sStart, sFlush, sPixelValid;
  logic [15:0] sPixelIn;
  logic        sPixelReady, sBusy, sDone, sWrite;
  logic [31:0] sAddr, sData;
  logic [3:0]  sBe;

  int checks = 0;
  int errors = 0;
  int mainDoneCount = 0;
  int smallDoneCount = 0;
  writeRec_t mainQ[$];
  writeRec_t smallQ[$];
  vector_t vectors[4];

  vga_dram_writer dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (start),
    .write_to_addr       (writeToAddr),
    .flush               (flush),
    .pixel_in            (pixelIn),
    .pixel_valid         (pixelValid),
    .pixel_ready         (pixelReady),
    .busy                (busy),
    .done                (done),
    .master_address      (mAddr),
    .master_write        (mWrite),
    .master_writedata    (mData),
    .master_byteenable   (mBe),
    .master_wait_request (waitReq)
  );

  vga_dram_writer #(.TOTAL_WORDS(4), .WORDS_W(3), .FIFO_AW(4)) dutSmall (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (sStart),
    .write_to_addr       (writeToAddr),
    .flush               (sFlush),
    .pixel_in            (sPixelIn),
    .pixel_valid         (sPixelValid),
    .pixel_ready         (sPixelReady),
    .busy                (sBusy),
    .done                (sDone),
    .master_address      (sAddr),
    .master_write        (sWrite),
    .master_writedata    (sData),
    .master_byteenable   (sBe),
    .master_wait_request (waitReq)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every write the slave accepts and counts done pulses
  always begin
    @(negedge clk);
    #2;
    if (resetn) begin
      if (mWrite && !waitReq) mainQ.push_back('{addr: mAddr, data: mData, be: mBe});
      if (sWrite && !waitReq) smallQ.push_back('{addr: sAddr, data: sData, be: sBe});
      if (done)  mainDoneCount++;
      if (sDone) smallDoneCount++;
    end
  end

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic useSmall, input logic st, input logic v,
                               input logic [15:0] p, input logic fl);
    @(negedge clk);
    if (useSmall) begin
      sStart = st; sPixelValid = v; sPixelIn = p; sFlush = fl;
    end else begin
      start = st; pixelValid = v; pixelIn = p; flush = fl;
    end
    #1;
  endtask

  task automatic sendPixel(input logic useSmall, input logic [15:0] p);
    int n;
    logic rdy;
    n = 0;
    applyStimulus(useSmall, 1'b0, 1'b1, p, 1'b0);
    rdy = useSmall ? sPixelReady : pixelReady;
    while (!rdy && n < 200) begin
      @(negedge clk);
      #1;
      rdy = useSmall ? sPixelReady : pixelReady;
      n++;
    end
    if (!rdy) checkOutput($sformatf("pixel %04h handshake", p), rdy, 1'b1);
    @(posedge clk);
    #1;
    if (useSmall) sPixelValid = 1'b0;
    else          pixelValid  = 1'b0;
  endtask

  task automatic startFrame(input logic useSmall, input logic [31:0] addr);
    writeToAddr = addr;
    applyStimulus(useSmall, 1'b1, 1'b0, 16'h0, 1'b0);
    applyStimulus(useSmall, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic flushFrame(input logic useSmall);
    applyStimulus(useSmall, 1'b0, 1'b0, 16'h0, 1'b1);
    applyStimulus(useSmall, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic waitDone(input logic useSmall, input string name);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < 500 && !seen) begin
      @(negedge clk);
      #1;
      if (useSmall ? sDone : done) begin
        seen = 1'b1;
        checkOutput($sformatf("%s busy with done", name), useSmall ? sBusy : busy, 1'b0);
      end
      n++;
    end
    checkOutput($sformatf("%s done seen", name), seen, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic checkWrite(input logic useSmall, input string name, input logic [31:0] expAddr,
                            input logic [31:0] expData, input logic [3:0] expBe);
    writeRec_t w;
    logic have;
    w = '0;
    if (useSmall) begin
      have = (smallQ.size() > 0);
      if (have) w = smallQ.pop_front();
    end else begin
      have = (mainQ.size() > 0);
      if (have) w = mainQ.pop_front();
    end
    checkOutput($sformatf("%s present", name), have, 1'b1);
    if (have) begin
      checkOutput($sformatf("%s addr", name), w.addr, expAddr);
      checkOutput($sformatf("%s data", name), w.data, expData);
      checkOutput($sformatf("%s be", name), 32'(w.be), 32'(expBe));
    end
  endtask

  initial begin
    int k;
    vectors[0] = '{32'h0000_0000, 16'h1234, 16'h5678, 1'b1, 32'h0000_0000, 32'h5678_1234, 4'hF};
    vectors[1] = '{32'hFFFF_FFFD, 16'hABCD, 16'h0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_ABCD, 4'h3};
    vectors[2] = '{32'h1234_5677, 16'h0001, 16'hFFFF, 1'b1, 32'h1234_5674, 32'hFFFF_0001, 4'hF};
    vectors[3] = '{32'h8000_0002, 16'h7FFF, 16'h0000, 1'b0, 32'h8000_0000, 32'h0000_7FFF, 4'h3};

    resetn = 1'b0; waitReq = 1'b0; writeToAddr = '0;
    start = 0; flush = 0; pixelValid = 0; pixelIn = '0;
    sStart = 0; sFlush = 0; sPixelValid = 0; sPixelIn = '0;

    // Reset held while inputs toggle: every output stays at zero
    for (int i = 0; i < 6; i++) begin
      writeToAddr = 32'h1357_9BDF ^ 32'(i);
      waitReq = i[0];
      applyStimulus(1'b0, ~i[0], i[0], 16'hA5A5, i[1]);
      checkOutput($sformatf("reset pixel_ready %0d", i), pixelReady, 1'b0);
      checkOutput($sformatf("reset busy %0d", i), busy, 1'b0);
      checkOutput($sformatf("reset done %0d", i), done, 1'b0);
      checkOutput($sformatf("reset address %0d", i), mAddr, 32'h0);
      checkOutput($sformatf("reset write %0d", i), mWrite, 1'b0);
      checkOutput($sformatf("reset writedata %0d", i), mData, 32'h0);
      checkOutput($sformatf("reset byteenable %0d", i), 32'(mBe), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    waitReq = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("post-reset busy", busy, 1'b0);
    checkOutput("post-reset pixel_ready", pixelReady, 1'b0);
    checkOutput("post-reset small busy", sBusy, 1'b0);

    // Basic two-word frame, including first-write latency
    mainQ.delete(); mainDoneCount = 0;
    startFrame(1'b0, 32'h0010_0000);
    checkOutput("basic busy after start", busy, 1'b1);
    sendPixel(1'b0, 16'h1111);
    sendPixel(1'b0, 16'h2222);
    checkOutput("latency write", mWrite, 1'b1);
    checkOutput("latency addr", mAddr, 32'h0010_0000);
    checkOutput("latency data", mData, 32'h2222_1111);
    sendPixel(1'b0, 16'h3333);
    sendPixel(1'b0, 16'h4444);
    flushFrame(1'b0);
    waitDone(1'b0, "basic");
    checkWrite(1'b0, "basic w0", 32'h0010_0000, 32'h2222_1111, 4'hF);
    checkWrite(1'b0, "basic w1", 32'h0010_0004, 32'h4444_3333, 4'hF);
    checkOutput("basic extra writes", 32'(mainQ.size()), 32'h0);
    checkOutput("basic done count", 32'(mainDoneCount), 32'h1);

    // Single-word frames from the vector table
    for (int v = 0; v < 4; v++) begin
      mainQ.delete(); mainDoneCount = 0;
      startFrame(1'b0, vectors[v].baseAddr);
      sendPixel(1'b0, vectors[v].pix0);
      if (vectors[v].twoPix) sendPixel(1'b0, vectors[v].pix1);
      flushFrame(1'b0);
      waitDone(1'b0, $sformatf("vec%0d", v));
      checkWrite(1'b0, $sformatf("vec%0d", v), vectors[v].expAddr, vectors[v].expData, vectors[v].expBe);
      checkOutput($sformatf("vec%0d extra writes", v), 32'(mainQ.size()), 32'h0);
      checkOutput($sformatf("vec%0d done count", v), 32'(mainDoneCount), 32'h1);
    end

    // Long stall: FIFO fills, request stays stable, nothing lost afterwards
    mainQ.delete(); mainDoneCount = 0;
    startFrame(1'b0, 32'h0030_0000);
    waitReq = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h0100 + k), 1'b0);
      if (mWrite) begin
        checkOutput($sformatf("stall addr c%0d", c), mAddr, 32'h0030_0000);
        checkOutput($sformatf("stall data c%0d", c), mData, 32'h0101_0100);
        checkOutput($sformatf("stall be c%0d", c), 32'(mBe), 32'hF);
      end
      if (pixelReady) k++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("stall accepted pixels", 32'(k), 32'd32);
    checkOutput("stall pixel_ready low", pixelReady, 1'b0);
    checkOutput("stall write held", mWrite, 1'b1);
    waitReq = 1'b0;
    while (k < 40) begin
      sendPixel(1'b0, 16'(16'h0100 + k));
      k++;
    end
    flushFrame(1'b0);
    waitDone(1'b0, "stall");
    for (int i = 0; i < 20; i++)
      checkWrite(1'b0, $sformatf("stall w%0d", i), 32'h0030_0000 + 32'(4 * i),
                 {16'(16'h0100 + 2 * i + 1), 16'(16'h0100 + 2 * i)}, 4'hF);
    checkOutput("stall extra writes", 32'(mainQ.size()), 32'h0);

    // Four-word frame ends by itself
    smallQ.delete(); smallDoneCount = 0;
    startFrame(1'b1, 32'h0040_0000);
    for (int i = 0; i < 8; i++) sendPixel(1'b1, 16'(16'h1000 + i));
    checkOutput("small ready after last pixel", sPixelReady, 1'b0);
    waitDone(1'b1, "small");
    checkOutput("small done count", 32'(smallDoneCount), 32'h1);
    for (int i = 0; i < 4; i++)
      checkWrite(1'b1, $sformatf("small w%0d", i), 32'h0040_0000 + 32'(4 * i),
                 {16'(16'h1000 + 2 * i + 1), 16'(16'h1000 + 2 * i)}, 4'hF);
    checkOutput("small extra writes", 32'(smallQ.size()), 32'h0);

    // Flush with a held pixel and a pixel offered in the flush cycle
    mainQ.delete(); mainDoneCount = 0;
    startFrame(1'b0, 32'h0050_0000);
    sendPixel(1'b0, 16'h1111);
    sendPixel(1'b0, 16'h2222);
    sendPixel(1'b0, 16'h3333);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4444, 1'b1);
    checkOutput("flush blocks pixel", pixelReady, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    waitDone(1'b0, "flush");
    checkWrite(1'b0, "flush w0", 32'h0050_0000, 32'h2222_1111, 4'hF);
    checkWrite(1'b0, "flush w1", 32'h0050_0004, 32'h0000_3333, 4'h3);
    checkOutput("flush extra writes", 32'(mainQ.size()), 32'h0);

    // Misaligned base, second start while busy is ignored
    mainQ.delete(); mainDoneCount = 0;
    startFrame(1'b0, 32'h0020_0003);
    sendPixel(1'b0, 16'hAAAA);
    sendPixel(1'b0, 16'hBBBB);
    startFrame(1'b0, 32'h0090_0000);
    checkOutput("restart busy", busy, 1'b1);
    sendPixel(1'b0, 16'hCCCC);
    sendPixel(1'b0, 16'hDDDD);
    flushFrame(1'b0);
    waitDone(1'b0, "restart");
    checkWrite(1'b0, "restart w0", 32'h0020_0000, 32'hBBBB_AAAA, 4'hF);
    checkWrite(1'b0, "restart w1", 32'h0020_0004, 32'hDDDD_CCCC, 4'hF);
    checkOutput("restart extra writes", 32'(mainQ.size()), 32'h0);
    checkOutput("restart done count", 32'(mainDoneCount), 32'h1);

    // Address wraps past the top of the 32-bit space
    mainQ.delete(); mainDoneCount = 0;
    startFrame(1'b0, 32'hFFFF_FFFE);
    for (int i = 1; i <= 4; i++) sendPixel(1'b0, 16'(i));
    flushFrame(1'b0);
    waitDone(1'b0, "wrap");
    checkWrite(1'b0, "wrap w0", 32'hFFFF_FFFC, 32'h0002_0001, 4'hF);
    checkWrite(1'b0, "wrap w1", 32'h0000_0000, 32'h0004_0003, 4'hF);
    checkOutput("wrap extra writes", 32'(mainQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
